seq_divider: RTL and testbench

Parametrised, multi-cycle restoring divider. It computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor in unsigned or signed (two's-complement) mode, one quotient bit per clock. A start/done handshake lets it sit beside the existing combinational 4-bit divider in the datapath where wider operands would make a single-cycle array too slow. It also flags divide-by-zero.

---
 rtl/seq_divider_pkg.sv | 18 +
 rtl/seq_divider_if.sv | 22 ++
 rtl/seq_divider_step.sv | 22 ++
 rtl/seq_divider.sv | 138 +++++++++++++
 tb/tb_seq_divider.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divider_pkg;

   typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_t;

   // Two's-complement magnitude of the low 'width' bits of value, zero-extended.
   function automatic logic [31:0] abs_val(input logic [31:0] value, input int unsigned width);
      logic [31:0] mask;
      logic [31:0] sign_vec;
      mask     = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      sign_vec = value >> (width - 1);
      if (sign_vec[0])
         abs_val = (~value + 32'd1) & mask;
      else
         abs_val = value & mask;
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle of the sequential divider.
interface seq_divider_if #(parameter int WIDTH = 8);
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, signed_mode, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, signed_mode, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, select.
module divider_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] dvsr,
   output logic [WIDTH:0]   rem_out,
   output logic [WIDTH-1:0] quo_out
);
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;
   logic             q_bit;

   always_comb begin
      shifted = {rem_in, quo_in[WIDTH-1]};
      trial   = shifted - {2'b00, dvsr};
      q_bit   = ~trial[WIDTH+1];
      rem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
      quo_out = {quo_in[WIDTH-2:0], q_bit};
   end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider, one quotient bit per clock.
module seq_divider
   import divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic        clock,
   input  logic        reset_n,
   seq_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   div_state_t       state_reg, state_next;
   logic [CW-1:0]    count_reg, count_next;
   logic [WIDTH:0]   rem_reg, rem_next;
   logic [WIDTH-1:0] quo_reg, quo_next;
   logic [WIDTH-1:0] dvsr_reg, dvsr_next;
   logic             q_sign_reg, q_sign_next;
   logic             r_sign_reg, r_sign_next;
   logic             zero_reg, zero_next;
   logic             zero_wait_reg, zero_wait_next;
   logic [WIDTH-1:0] quotient_reg, quotient_next;
   logic [WIDTH-1:0] remainder_reg, remainder_next;
   logic             dbz_reg, dbz_next;
   logic             done_reg, done_next;

   logic [WIDTH:0]   step_rem;
   logic [WIDTH-1:0] step_quo;
   logic [WIDTH-1:0] dvd_mag, dvs_mag, rem_src;

   divider_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_reg),
      .quo_in  (quo_reg),
      .dvsr    (dvsr_reg),
      .rem_out (step_rem),
      .quo_out (step_quo)
   );

   always_comb begin
      dvd_mag = bus.signed_mode ? WIDTH'(abs_val(32'(bus.dividend), WIDTH)) : bus.dividend;
      dvs_mag = bus.signed_mode ? WIDTH'(abs_val(32'(bus.divisor), WIDTH)) : bus.divisor;
      // With a zero divisor no iteration runs, so quo_reg still holds the dividend magnitude.
      rem_src = zero_reg ? quo_reg : rem_reg[WIDTH-1:0];
   end

   always_comb begin
      state_next     = state_reg;
      count_next     = count_reg;
      rem_next       = rem_reg;
      quo_next       = quo_reg;
      dvsr_next      = dvsr_reg;
      q_sign_next    = q_sign_reg;
      r_sign_next    = r_sign_reg;
      zero_next      = zero_reg;
      zero_wait_next = zero_wait_reg;
      quotient_next  = quotient_reg;
      remainder_next = remainder_reg;
      dbz_next       = dbz_reg;
      done_next      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               quo_next       = dvd_mag;
               dvsr_next      = dvs_mag;
               q_sign_next    = bus.signed_mode & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
               r_sign_next    = bus.signed_mode & bus.dividend[WIDTH-1];
               rem_next       = '0;
               count_next     = CW'(WIDTH - 1);
               zero_next      = (bus.divisor == '0);
               zero_wait_next = (bus.divisor == '0);
               state_next     = (bus.divisor == '0) ? FIX : CALC;
            end
         end
         CALC: begin
            rem_next = step_rem;
            quo_next = step_quo;
            if (count_reg == '0)
               state_next = FIX;
            else
               count_next = count_reg - CW'(1);
         end
         FIX: begin
            // A zero divisor lingers one extra cycle here so its done lands two cycles after start.
            if (zero_wait_reg) begin
               zero_wait_next = 1'b0;
            end else begin
               if (zero_reg)
                  quotient_next = '1;
               else
                  quotient_next = q_sign_reg ? (~quo_reg + WIDTH'(1)) : quo_reg;
               remainder_next = r_sign_reg ? (~rem_src + WIDTH'(1)) : rem_src;
               dbz_next       = zero_reg;
               done_next      = 1'b1;
               state_next     = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         count_reg     <= '0;
         rem_reg       <= '0;
         quo_reg       <= '0;
         dvsr_reg      <= '0;
         q_sign_reg    <= 1'b0;
         r_sign_reg    <= 1'b0;
         zero_reg      <= 1'b0;
         zero_wait_reg <= 1'b0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         dbz_reg       <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         count_reg     <= count_next;
         rem_reg       <= rem_next;
         quo_reg       <= quo_next;
         dvsr_reg      <= dvsr_next;
         q_sign_reg    <= q_sign_next;
         r_sign_reg    <= r_sign_next;
         zero_reg      <= zero_next;
         zero_wait_reg <= zero_wait_next;
         quotient_reg  <= quotient_next;
         remainder_reg <= remainder_next;
         dbz_reg       <= dbz_next;
         done_reg      <= done_next;
      end
   end

   assign bus.busy        = (state_reg != IDLE);
   assign bus.done        = done_reg;
   assign bus.quotient    = quotient_reg;
   assign bus.remainder   = remainder_reg;
   assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of seq_divider at WIDTH=8 and WIDTH=4.
module tb_seq_divider;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   seq_divider_if #(.WIDTH(8)) bus8 ();
   seq_divider_if #(.WIDTH(4)) bus4 ();

   seq_divider #(.WIDTH(8)) dut8 (.clock(clock), .reset_n(reset_n), .bus(bus8));
   seq_divider #(.WIDTH(4)) dut4 (.clock(clock), .reset_n(reset_n), .bus(bus4));

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one start pulse; returns #1 after the accepting edge.
   task automatic start8(input logic sm, input logic [7:0] a, input logic [7:0] b);
      @(negedge clock);
      bus8.start = 1'b1; bus8.signed_mode = sm; bus8.dividend = a; bus8.divisor = b;
      @(posedge clock); #1;
      bus8.start = 1'b0;
   endtask

   // Counts edges until done (bounded) and busy samples before it.
   task automatic wait8(output int lat, output int busy_n);
      logic got;
      got = 1'b0; lat = 0; busy_n = bus8.busy ? 1 : 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clock); #1;
         lat++;
         if (bus8.done) got = 1'b1;
         else if (bus8.busy) busy_n++;
      end
   endtask

   task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                      output int lat, output int busy_n);
      start8(sm, a, b);
      wait8(lat, busy_n);
      $display("op8 sm=%0d %0h/%0h -> q=%0h r=%0h z=%0b lat=%0d", sm, a, b,
               bus8.quotient, bus8.remainder, bus8.div_by_zero, lat);
   endtask

   task automatic op4(input logic sm, input logic [3:0] a, input logic [3:0] b);
      int lat, eq, er, sa, sb;
      logic got;
      logic [8:0] exp_v;
      logic [3:0] eq4, er4;
      @(negedge clock);
      bus4.start = 1'b1; bus4.signed_mode = sm; bus4.dividend = a; bus4.divisor = b;
      @(posedge clock); #1;
      bus4.start = 1'b0;
      got = 1'b0; lat = 0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(posedge clock); #1;
         lat++;
         if (bus4.done) got = 1'b1;
      end
      if (b == 4'd0) begin
         exp_v = {1'b1, a, 4'hF};
      end else begin
         if (sm) begin
            sa = a[3] ? int'(a) - 16 : int'(a);
            sb = b[3] ? int'(b) - 16 : int'(b);
         end else begin
            sa = int'(a);
            sb = int'(b);
         end
         eq = sa / sb;
         er = sa % sb;
         eq4 = eq[3:0];
         er4 = er[3:0];
         exp_v = {1'b0, er4, eq4};
      end
      $display("op4 sm=%0d %0h/%0h -> q=%0h r=%0h z=%0b lat=%0d", sm, a, b,
               bus4.quotient, bus4.remainder, bus4.div_by_zero, lat);
      check("w4_result", {bus4.div_by_zero, bus4.remainder, bus4.quotient}, exp_v);
      check("w4_latency", lat, (b == 4'd0) ? 2 : 5);
   endtask

   initial begin
      int lat, busy_n;
      logic saw_done;
      bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.dividend = '0; bus8.divisor = '0;
      bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.dividend = '0; bus4.divisor = '0;

      repeat (2) @(posedge clock);
      #1;
      check("reset_outputs", {bus8.busy, bus8.done, bus8.quotient, bus8.remainder, bus8.div_by_zero}, '0);
      @(negedge clock);
      reset_n = 1'b1;

      // Unsigned 15 / 2
      op8(1'b0, 8'd15, 8'd2, lat, busy_n);
      check("s1_latency", lat, 9);
      check("s1_busy_cycles", busy_n, 9);
      check("s1_busy_at_done", bus8.busy, 1'b0);
      check("s1_quotient", bus8.quotient, 8'd7);
      check("s1_remainder", bus8.remainder, 8'd1);
      check("s1_dbz", bus8.div_by_zero, 1'b0);
      @(posedge clock); #1;
      check("s1_done_one_cycle", bus8.done, 1'b0);
      check("s1_quotient_held", bus8.quotient, 8'd7);

      // Signed -7 / 2 and 7 / -2
      op8(1'b1, 8'hF9, 8'h02, lat, busy_n);
      check("s2a_quotient", bus8.quotient, 8'hFD);
      check("s2a_remainder", bus8.remainder, 8'hFF);
      op8(1'b1, 8'h07, 8'hFE, lat, busy_n);
      check("s2b_quotient", bus8.quotient, 8'hFD);
      check("s2b_remainder", bus8.remainder, 8'h01);

      // Divide by zero, then a normal divide clears the flag
      op8(1'b0, 8'd200, 8'd0, lat, busy_n);
      check("s3_dbz_latency", lat, 2);
      check("s3_dbz_quotient", bus8.quotient, 8'hFF);
      check("s3_dbz_remainder", bus8.remainder, 8'd200);
      check("s3_dbz_flag", bus8.div_by_zero, 1'b1);
      op8(1'b0, 8'd200, 8'd10, lat, busy_n);
      check("s3_quotient", bus8.quotient, 8'd20);
      check("s3_remainder", bus8.remainder, 8'd0);
      check("s3_dbz_cleared", bus8.div_by_zero, 1'b0);

      // Signed overflow -128 / -1
      op8(1'b1, 8'h80, 8'hFF, lat, busy_n);
      check("s4_quotient", bus8.quotient, 8'h80);
      check("s4_remainder", bus8.remainder, 8'h00);
      check("s4_dbz", bus8.div_by_zero, 1'b0);

      // Start pulsed during busy is ignored
      start8(1'b0, 8'd100, 8'd7);
      repeat (2) begin @(posedge clock); #1; end
      bus8.start = 1'b1; bus8.dividend = 8'd9; bus8.divisor = 8'd9;
      @(posedge clock); #1;
      bus8.start = 1'b0;
      wait8(lat, busy_n);
      $display("op8 sm=0 64/7 with busy start -> q=%0h r=%0h lat=%0d", bus8.quotient, bus8.remainder, lat + 3);
      check("s5a_latency", lat, 6);
      check("s5a_quotient", bus8.quotient, 8'd14);
      check("s5a_remainder", bus8.remainder, 8'd2);
      @(posedge clock); #1;
      check("s5a_no_second_op", bus8.busy, 1'b0);

      // Start held through done: back-to-back operation
      @(negedge clock);
      bus8.start = 1'b1; bus8.signed_mode = 1'b0; bus8.dividend = 8'd50; bus8.divisor = 8'd3;
      @(posedge clock); #1;
      bus8.dividend = 8'd90; bus8.divisor = 8'd9;
      wait8(lat, busy_n);
      $display("op8 sm=0 32/3 start held -> q=%0h r=%0h lat=%0d", bus8.quotient, bus8.remainder, lat);
      check("s5b_first_latency", lat, 9);
      check("s5b_first_quotient", bus8.quotient, 8'd16);
      check("s5b_first_remainder", bus8.remainder, 8'd2);
      @(posedge clock); #1;
      bus8.start = 1'b0;
      check("s5b_accepted", bus8.busy, 1'b1);
      wait8(lat, busy_n);
      $display("op8 sm=0 5a/9 back-to-back -> q=%0h r=%0h lat=%0d", bus8.quotient, bus8.remainder, lat);
      check("s5b_second_latency", lat, 9);
      check("s5b_second_quotient", bus8.quotient, 8'd10);
      check("s5b_second_remainder", bus8.remainder, 8'd0);

      // Reset mid-CALC
      start8(1'b0, 8'd200, 8'd3);
      repeat (3) begin @(posedge clock); #1; end
      reset_n = 1'b0;
      #1;
      check("s5c_reset_outputs", {bus8.busy, bus8.done, bus8.quotient, bus8.remainder, bus8.div_by_zero}, '0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clock); #1;
         if (bus8.done || bus8.busy) saw_done = 1'b1;
      end
      $display("op8 sm=0 c8/3 aborted by reset -> activity=%0b", saw_done);
      check("s5c_no_done_after_reset", saw_done, 1'b0);

      // Exhaustive WIDTH=4
      for (int sm = 0; sm < 2; sm++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
               op4(sm[0], a[3:0], b[3:0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
